// File: rtl/adder_tree_acc.sv
// Registered binary adder tree over LANES unsigned lanes with an optional per-frame
// accumulator and a valid/ready result port carrying beat count and sticky overflow.
module adder_tree_acc #(
  parameter int LANES  = 8,
  parameter int LANE_W = 64,
  parameter int OUT_W  = 64,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*LANE_W-1:0] din,
  input  logic                    din_tvalid,
  output logic                    din_tready,
  input  logic                    din_tlast,
  input  logic                    acc_en,
  output logic [OUT_W-1:0]        dout,
  output logic                    dout_tvalid,
  input  logic                    dout_tready,
  output logic                    dout_ovf,
  output logic [CNT_W-1:0]        dout_beats
);

  localparam int LVL   = $clog2(LANES);
  localparam int SUM_W = LANE_W + LVL;
  localparam int EXT_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

  // Handshake: a beat moves on any edge where valid && ready. The whole pipe
  // advances as one unit whenever the output register is empty or being drained,
  // so din_tready is that same enable and no stage ever needs a skid buffer.
  logic en;
  assign en         = !dout_tvalid || dout_tready;
  assign din_tready = en;

  // Stage 0 is the input capture register; stages 1..LVL are tree levels.
  logic [LANES*LANE_W-1:0] din_q;
  logic [LVL:0]            v_q;
  logic [LVL:0]            a_q;
  logic [LVL:0]            l_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      a_q <= '0;
      l_q <= '0;
    end else if (en) begin
      v_q[0] <= din_tvalid;
      a_q[0] <= acc_en;
      l_q[0] <= din_tlast;
      for (int k = 1; k <= LVL; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        l_q[k] <= l_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) din_q <= din;
  end

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int N = LANES >> (k + 1);
    localparam int W = LANE_W + k + 1;
    for (genvar j = 0; j < N; j++) begin : g_node
      logic [W-1:0] sum_d;
      logic [W-1:0] sum_q;
      if (k == 0) begin : g_leaf
        assign sum_d = W'(din_q[2*j*LANE_W +: LANE_W])
                     + W'(din_q[(2*j+1)*LANE_W +: LANE_W]);
      end else begin : g_inner
        assign sum_d = W'(g_lvl[k-1].g_node[2*j].sum_q)
                     + W'(g_lvl[k-1].g_node[2*j+1].sum_q);
      end
      always_ff @(posedge clk) begin
        if (en) sum_q <= sum_d;
      end
    end
  end

  logic [SUM_W-1:0] s_sum;
  logic [EXT_W-1:0] s_ext;
  logic [OUT_W-1:0] s_mod;
  logic             s_big;
  logic [OUT_W:0]   t_sum;
  logic             new_ovf;
  logic [CNT_W-1:0] cnt_inc;

  logic [OUT_W-1:0] acc_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] dout_q;
  logic             vld_q;
  logic             ovf_q;
  logic [CNT_W-1:0] beats_q;

  assign s_sum   = g_lvl[LVL-1].g_node[0].sum_q;
  assign s_ext   = EXT_W'(s_sum);
  assign s_mod   = s_ext[OUT_W-1:0];
  assign s_big   = |(s_ext >> OUT_W);
  assign t_sum   = {1'b0, acc_q} + {1'b0, s_mod};
  assign new_ovf = t_sum[OUT_W] | s_big;
  // The beat counter saturates rather than wrapping on very long frames.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      beats_q  <= '0;
    end else if (en) begin
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      beats_q <= '0;
      if (v_q[LVL]) begin
        if (!a_q[LVL]) begin
          // Pass beat: reported alone, the open frame (if any) is left intact.
          dout_q  <= s_mod;
          ovf_q   <= s_big;
          beats_q <= CNT_W'(1);
          vld_q   <= 1'b1;
        end else if (!l_q[LVL]) begin
          acc_q    <= t_sum[OUT_W-1:0];
          sticky_q <= sticky_q | new_ovf;
          cnt_q    <= cnt_inc;
        end else begin
          dout_q   <= t_sum[OUT_W-1:0];
          ovf_q    <= sticky_q | new_ovf;
          beats_q  <= cnt_inc;
          vld_q    <= 1'b1;
          acc_q    <= '0;
          sticky_q <= 1'b0;
          cnt_q    <= '0;
        end
      end
    end
  end

  assign dout        = dout_q;
  assign dout_tvalid = vld_q;
  assign dout_ovf    = ovf_q;
  assign dout_beats  = beats_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: driver pushes expected results into a queue,
// a negedge monitor pops and compares every output transfer.
module tb_adder_tree_acc;

  localparam int LANES  = 8;
  localparam int LANE_W = 64;
  localparam int OUT_W  = 64;
  localparam int CNT_W  = 16;
  localparam int EXP_W  = OUT_W + 1 + CNT_W;

  logic                    clk;
  logic                    rst_n;
  logic [LANES*LANE_W-1:0] din;
  logic                    din_tvalid;
  logic                    din_tready;
  logic                    din_tlast;
  logic                    acc_en;
  logic [OUT_W-1:0]        dout;
  logic                    dout_tvalid;
  logic                    dout_tready;
  logic                    dout_ovf;
  logic [CNT_W-1:0]        dout_beats;

  adder_tree_acc #(.LANES(LANES), .LANE_W(LANE_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_tvalid(din_tvalid),
    .din_tready(din_tready), .din_tlast(din_tlast), .acc_en(acc_en),
    .dout(dout), .dout_tvalid(dout_tvalid), .dout_tready(dout_tready),
    .dout_ovf(dout_ovf), .dout_beats(dout_beats)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LANES*LANE_W-1:0] all_lanes(input logic [LANE_W-1:0] v);
    logic [LANES*LANE_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  function automatic logic [EXP_W-1:0] mk_exp(input logic [OUT_W-1:0] d, input logic o,
                                              input logic [CNT_W-1:0] b);
    return {d, o, b};
  endfunction

  // driver: called at posedge+1, returns at posedge+1 after the accepting edge
  task automatic send(input logic [LANES*LANE_W-1:0] data, input logic acc, input logic last,
                      input logic push, input logic [EXP_W-1:0] exp, output int waited);
    waited = 0;
    din = data;
    acc_en = acc;
    din_tlast = last;
    din_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (din_tready) break;
      waited++;
      if (waited > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: din_tready stuck 0, required 1");
        $fatal(1, "send timeout");
      end
    end
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    din_tvalid = 1'b0;
    din_tlast = 1'b0;
    acc_en = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && dout_tvalid && dout_tready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got dout=%0h ovf=%0b beats=%0d, required no output",
                 dout, dout_ovf, dout_beats);
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        n_vec++;
        if ({dout, dout_ovf, dout_beats} !== e) begin
          n_err++;
          $display("FAIL result: got dout=%0h ovf=%0b beats=%0d, required dout=%0h ovf=%0b beats=%0d",
                   dout, dout_ovf, dout_beats, e[EXP_W-1 -: OUT_W], e[CNT_W], e[CNT_W-1:0]);
        end
      end
    end
  end

  task automatic stall_check();
    logic [OUT_W-1:0] held;
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      if (dout_tvalid || c > 50) break;
    end
    chk("stall_saw_valid", dout_tvalid, 1);
    dout_tready = 1'b0;
    held = dout;
    repeat (5) begin
      @(negedge clk);
      chk("stall_din_tready", din_tready, 0);
      chk("stall_dout_hold", dout, held);
      chk("stall_valid_hold", dout_tvalid, 1);
    end
    @(posedge clk);
    #1;
    dout_tready = 1'b1;
  endtask

  initial begin
    int w;
    logic [LANES*LANE_W-1:0] seq;
    rst_n = 1'b0;
    din = '0;
    din_tvalid = 1'b0;
    din_tlast = 1'b0;
    acc_en = 1'b0;
    dout_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", dout_tvalid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", dout_ovf, 0);
    chk("rst_beats", dout_beats, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: lanes 1..8, latency 4
    for (int i = 0; i < LANES; i++) seq[i*LANE_W +: LANE_W] = LANE_W'(i + 1);
    send(seq, 1'b0, 1'b0, 1'b1, mk_exp(64'd36, 1'b0, 16'd1), w);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("lat_early_valid", dout_tvalid, 0);
    end
    @(posedge clk);
    #1;
    chk("lat_valid_at_4", dout_tvalid, 1);
    drain();

    // 2: back-to-back pass beats
    for (int n = 1; n <= 10; n++) begin
      send(all_lanes(LANE_W'(n)), 1'b0, 1'b0, 1'b1, mk_exp(OUT_W'(8 * n), 1'b0, 16'd1), w);
      chk("b2b_no_wait", w, 0);
    end
    drain();

    // 3: backpressure with inputs pending
    fork
      begin
        for (int n = 11; n <= 18; n++)
          send(all_lanes(LANE_W'(n)), 1'b0, 1'b0, 1'b1, mk_exp(OUT_W'(8 * n), 1'b0, 16'd1), w);
      end
      stall_check();
    join
    drain();

    // 4: 3-beat frame, then a fresh 1-beat frame
    send(all_lanes(64'd1), 1'b1, 1'b0, 1'b0, '0, w);
    send(all_lanes(64'd1), 1'b1, 1'b0, 1'b0, '0, w);
    send(all_lanes(64'd1), 1'b1, 1'b1, 1'b1, mk_exp(64'd24, 1'b0, 16'd3), w);
    send(all_lanes(64'd2), 1'b1, 1'b1, 1'b1, mk_exp(64'd16, 1'b0, 16'd1), w);
    // pass beat inside an open frame
    send(all_lanes(64'd1), 1'b1, 1'b0, 1'b0, '0, w);
    send(all_lanes(64'd2), 1'b0, 1'b0, 1'b1, mk_exp(64'd16, 1'b0, 16'd1), w);
    send(all_lanes(64'd1), 1'b1, 1'b1, 1'b1, mk_exp(64'd16, 1'b0, 16'd2), w);
    // tlast on a pass beat has no effect
    send(all_lanes(64'd4), 1'b0, 1'b1, 1'b1, mk_exp(64'd32, 1'b0, 16'd1), w);
    drain();

    // 5: overflow cases
    send(all_lanes(64'hFFFF_FFFF_FFFF_FFFF), 1'b0, 1'b0, 1'b1,
         mk_exp(64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 16'd1), w);
    send(all_lanes(64'h1000_0000_0000_0000), 1'b1, 1'b0, 1'b0, '0, w);
    send(all_lanes(64'h1000_0000_0000_0000), 1'b1, 1'b1, 1'b1, mk_exp(64'd0, 1'b1, 16'd2), w);
    send(all_lanes(64'd3), 1'b1, 1'b1, 1'b1, mk_exp(64'd24, 1'b0, 16'd1), w);
    send(all_lanes(64'h4000_0000_0000_0000), 1'b1, 1'b0, 1'b0, '0, w);
    send(all_lanes(64'd1), 1'b1, 1'b1, 1'b1, mk_exp(64'd8, 1'b1, 16'd2), w);
    drain();

    // 6: reset discards an open frame
    send(all_lanes(64'd5), 1'b1, 1'b0, 1'b0, '0, w);
    send(all_lanes(64'd5), 1'b1, 1'b0, 1'b0, '0, w);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_tvalid", dout_tvalid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_ovf", dout_ovf, 0);
    chk("mid_rst_beats", dout_beats, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(all_lanes(64'd1), 1'b1, 1'b1, 1'b1, mk_exp(64'd8, 1'b0, 16'd1), w);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
